// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: defaults, FSM states, FIFO entry layout.
package if_fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam int unsigned IM_AW_DEF    = 10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_e;

  // {fault, pc, instr}
  typedef struct packed {
    logic        fault;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/if_fetch_ctrl_fetch_fifo.sv
// Small synchronous FIFO with flush and asynchronous clear; output reads 0 when empty.
module fetch_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Storage write; when full with a same-cycle pop, the slot being read is the one rewritten.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; flush discards everything, including a same-cycle push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign count = r_count;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives the IM index, buffers {pc, instr}
// pairs for decode and handles redirects and fetch faults.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int unsigned IM_AW     = IM_AW_DEF,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic [IM_AW-1:0] im_index,
  input  logic [31:0]      im_rdata,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc,
  output logic             id_fault,
  output logic [31:0]      fetch_pc
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic         w_bad;
  logic         w_pop;
  logic         w_push;
  logic [CW-1:0] w_count;
  fetch_entry_t w_din;
  fetch_entry_t w_dout;

  assign w_bad = (r_pc[1:0] != 2'b00) ||
                 (r_pc[31:IM_AW+2] != RESET_PC[31:IM_AW+2]);

  assign id_valid = (w_count != '0);
  assign w_pop    = id_valid && id_ready;
  assign w_push   = (r_state == ST_RUN) && !redirect_valid &&
                    ((w_count < CW'(BUF_DEPTH)) || w_pop);

  // PC and FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_state <= ST_RUN;
    end else begin
      r_pc    <= w_pc_nxt;
      r_state <= w_state_nxt;
    end
  end

  // Next PC/state and push payload; redirect overrides any fetch activity.
  always_comb begin
    w_pc_nxt       = r_pc;
    w_state_nxt    = r_state;
    w_din.fault    = w_bad;
    w_din.pc       = r_pc;
    w_din.instr    = w_bad ? '0 : im_rdata;
    if (redirect_valid) begin
      w_pc_nxt    = redirect_pc;
      w_state_nxt = ST_RUN;
    end else if (w_push) begin
      if (w_bad) begin
        w_state_nxt = ST_FAULT;
      end else begin
        w_pc_nxt = r_pc + 32'd4;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect_valid),
    .din   (w_din),
    .dout  (w_dout),
    .count (w_count)
  );

  assign im_index = r_pc[IM_AW+1:2];
  assign fetch_pc = r_pc;
  assign id_instr = w_dout.instr;
  assign id_pc    = w_dout.pc;
  assign id_fault = w_dout.fault;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: expected entries are queued when fetch is (re)started
// and compared against every entry decode accepts.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  im_index;
  logic [31:0] im_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_fault;
  logic [31:0] fetch_pc;

  logic [31:0] im_mem [1024];
  logic [64:0] sb_q [$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  assign im_rdata = im_mem[im_index];

  if_fetch_ctrl #(
    .RESET_PC  (32'h0000_3000),
    .IM_AW     (10),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .im_index       (im_index),
    .im_rdata       (im_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_fault       (id_fault),
    .fetch_pc       (fetch_pc)
  );

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Expected program-order stream from start: legal words until the first bad PC, which
  // yields a single fault marker.
  task automatic sb_stream(input logic [31:0] start, input int unsigned n);
    logic [31:0] a;
    a = start;
    for (int unsigned k = 0; k < n; k++) begin
      if (a[1:0] != 2'b00 || a[31:12] != 20'h00003) begin
        sb_q.push_back({1'b1, a, 32'h0});
        break;
      end
      sb_q.push_back({1'b0, a, im_mem[a[11:2]]});
      a = a + 32'd4;
    end
  endtask

  task automatic sb_flush();
    sb_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare every accepted entry; the pop in a redirect cycle is discarded by decode.
  always @(negedge clk) begin
    if (!reset && id_valid && id_ready && !redirect_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", {id_fault, id_pc, id_instr}, 65'h0 - 65'h1);
      end else begin
        check("sb_entry", {id_fault, id_pc, id_instr}, sb_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int unsigned guard;
    logic [31:0] rp;

    for (int i = 0; i < 1024; i++) im_mem[i] = 32'(i + 1);
    rp             = 32'h0000_3000;
    reset          = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid",    id_valid, 0);
    check("rst_fault",    id_fault, 0);
    check("rst_instr",    id_instr, 0);
    check("rst_pc",       id_pc, 0);
    check("rst_fetch_pc", fetch_pc, 32'h3000);
    check("rst_im_index", im_index, rp[11:2]);

    // 1: streaming from RESET_PC, first entry one cycle after reset release
    tick();
    reset = 1'b0;
    sb_stream(32'h3000, 16);
    @(negedge clk);
    check("first_latency", id_valid, 0);
    repeat (4) begin
      @(negedge clk);
      check("stream_valid", id_valid, 1);
    end

    // 2: redirect to 3000 with decode stalled, then release
    tick();
    id_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3000;
    sb_flush();
    sb_stream(32'h3000, 16);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_gap", id_valid, 0);
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", id_valid, 1);
      check("stall_hold_pc", id_pc, 32'h3000);
    end
    check("stall_fetch_pc", fetch_pc, 32'h3008);
    tick();
    id_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("release_valid", id_valid, 1);
    end

    // 3: redirect to 3100 while full, with a concurrent pop
    tick();
    id_ready = 1'b0;
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3100;
    id_ready       = 1'b1;
    sb_flush();
    sb_stream(32'h3100, 2000);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("full_redir_gap", id_valid, 0);
    @(negedge clk);
    check("full_redir_valid", id_valid, 1);
    check("full_redir_pc", id_pc, 32'h3100);
    check("full_redir_instr", id_instr, im_mem[64]);

    // 4: run off the end of the IM window into the fault marker at 4000
    guard = 0;
    while (sb_q.size() != 0 && guard < 1500) begin
      @(posedge clk);
      guard++;
    end
    check("end_drain", guard < 1500, 1);
    repeat (3) begin
      @(negedge clk);
      check("end_stopped_valid", id_valid, 0);
    end
    check("end_fetch_pc", fetch_pc, 32'h4000);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3000;
    sb_flush();
    sb_stream(32'h3000, 32);
    tick();
    redirect_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("resume_valid", id_valid, 1);

    // 5: misaligned redirect faults without passing IM data
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3002;
    sb_flush();
    sb_stream(32'h3002, 4);
    tick();
    redirect_valid = 1'b0;
    guard = 0;
    while (sb_q.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    check("misalign_drain", guard < 20, 1);
    @(negedge clk);
    check("misalign_stopped", id_valid, 0);
    check("misalign_fetch_pc", fetch_pc, 32'h3002);

    // 6: asynchronous reset in mid-cycle with a full FIFO
    tick();
    id_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3000;
    sb_flush();
    tick();
    redirect_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    check("prereset_valid", id_valid, 1);
    reset = 1'b1;
    #1;
    check("async_rst_valid", id_valid, 0);
    check("async_rst_pc", id_pc, 0);
    check("async_rst_fetch_pc", fetch_pc, 32'h3000);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    id_ready = 1'b1;
    sb_stream(32'h3000, 16);
    @(negedge clk);
    check("restart_latency", id_valid, 0);
    @(negedge clk);
    check("restart_valid", id_valid, 1);
    check("restart_pc", id_pc, 32'h3000);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
